// File: rtl/vigenere_pkg.sv
// Shared constants, FSM state type and character-class helper for the
// streaming Vigenere encryptor.
package vigenere_pkg;

  localparam int DATA_W = 8;
  localparam logic [DATA_W-1:0] UPPERCASE_A_CHAR = 8'h41;
  localparam logic [DATA_W-1:0] UPPERCASE_Z_CHAR = 8'h5A;
  localparam logic [DATA_W-1:0] NUL_CHAR         = 8'h00;
  localparam int ALPHABET_LEN = 26;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN
  } enc_state_t;

  function automatic logic is_upper(input logic [DATA_W-1:0] ch);
    return (ch >= UPPERCASE_A_CHAR) && (ch <= UPPERCASE_Z_CHAR);
  endfunction

endpackage

// File: rtl/vigenere_enc_table.sv
// Combinational letter encryption: c = ((p - 'A') + (k - 'A')) mod 26 + 'A'.
// Mirror of the decryption table; only meaningful for uppercase p and k.
module vigenere_enc_table
  import vigenere_pkg::*;
(
  input  logic [DATA_W-1:0] p,
  input  logic [DATA_W-1:0] k,
  output logic [DATA_W-1:0] c
);

  logic [5:0] sum;
  logic [5:0] letter;

  // Both offsets are at most 25, so one conditional subtract closes the modulus.
  function automatic logic [5:0] wrap_alpha(input logic [5:0] s);
    return (s >= 6'(ALPHABET_LEN)) ? s - 6'(ALPHABET_LEN) : s;
  endfunction

  always_comb begin
    sum    = 6'(p - UPPERCASE_A_CHAR) + 6'(k - UPPERCASE_A_CHAR);
    letter = wrap_alpha(sum);
    c      = UPPERCASE_A_CHAR + {2'b00, letter};
  end

endmodule

// File: rtl/vigenere_cipher_enc.sv
// Streaming Vigenere encryptor: key load FSM, cyclic key store and a single
// ready/valid output register carrying one ciphertext character per cycle.
module vigenere_cipher_enc
  import vigenere_pkg::*;
#(
  parameter int KEY_MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] key_char,
  input  logic              key_valid,
  input  logic              key_last,
  input  logic              key_clear,
  output logic              key_loaded,
  output logic              key_err,
  input  logic [DATA_W-1:0] ptxt_char,
  input  logic              ptxt_valid,
  output logic              ptxt_ready,
  output logic [DATA_W-1:0] ctxt_char,
  output logic              ctxt_valid,
  output logic              ctxt_err,
  input  logic              ctxt_ready
);

  localparam int IDX_W = (KEY_MAX_LEN > 1) ? $clog2(KEY_MAX_LEN) : 1;
  localparam int LEN_W = $clog2(KEY_MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LAST_LEN = LEN_W'(KEY_MAX_LEN - 1);

  enc_state_t state, state_nx;

  logic [DATA_W-1:0] key_mem [KEY_MAX_LEN];
  logic [LEN_W-1:0]  key_len;
  logic [IDX_W-1:0]  key_idx;

  logic              key_acc;
  logic              key_ok;
  logic              key_bad;
  logic              key_done;
  logic              ptxt_acc;
  logic              ptxt_up;
  logic              idx_wrap;
  logic [DATA_W-1:0] enc_char;

  logic [DATA_W-1:0] ctxt_char_p1;
  logic              vld_p1;
  logic              err_p1;
  logic              key_err_p1;

  // Stage 0: handshake decode and table lookup against the current key entry
  always_comb begin
    key_acc    = !key_clear && key_valid && (state != RUN);
    key_ok     = key_acc && is_upper(key_char);
    key_bad    = key_acc && !is_upper(key_char);
    key_done   = key_ok && (key_last || (key_len == LAST_LEN));
    ptxt_ready = (state == RUN) && (!vld_p1 || ctxt_ready);
    ptxt_acc   = !key_clear && ptxt_valid && ptxt_ready;
    ptxt_up    = is_upper(ptxt_char);
    idx_wrap   = (LEN_W'(key_idx) == (key_len - LEN_W'(1)));
    key_loaded = (state == RUN);
  end

  vigenere_enc_table u_table (
    .p (ptxt_char),
    .k (key_mem[key_idx]),
    .c (enc_char)
  );

  always_comb begin
    state_nx = state;
    if (key_clear) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (key_bad)       state_nx = IDLE;
          else if (key_done) state_nx = RUN;
          else if (key_ok)   state_nx = LOAD;
        end
        RUN:     state_nx = RUN;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst || key_clear || key_bad) key_len <= '0;
    else if (key_ok)                 key_len <= key_len + LEN_W'(1);
  end

  // Key store is left unreset; entries at or above key_len are never read.
  always_ff @(posedge clk) begin
    if (key_ok) key_mem[key_len[IDX_W-1:0]] <= key_char;
  end

  always_ff @(posedge clk) begin
    if (rst)                      key_idx <= '0;
    else if (key_done)            key_idx <= '0;
    else if (ptxt_acc && ptxt_up) key_idx <= idx_wrap ? '0 : key_idx + IDX_W'(1);
  end

  // Stage 1: registered ciphertext, error flag and key-error pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1       <= 1'b0;
      err_p1       <= 1'b0;
      ctxt_char_p1 <= NUL_CHAR;
      key_err_p1   <= 1'b0;
    end else begin
      key_err_p1 <= key_bad;
      if (key_clear) begin
        vld_p1 <= 1'b0;
      end else if (ptxt_acc) begin
        vld_p1       <= 1'b1;
        err_p1       <= !ptxt_up;
        ctxt_char_p1 <= ptxt_up ? enc_char : NUL_CHAR;
      end else if (ctxt_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign ctxt_char  = ctxt_char_p1;
  assign ctxt_valid = vld_p1;
  assign ctxt_err   = err_p1;
  assign key_err    = key_err_p1;

endmodule

// File: tb/tb_vigenere_cipher_enc.sv
// Self-checking bench for vigenere_cipher_enc: vector table, corner-case
// sequences and a randomized stream scored against a modular-arithmetic model.
module tb_vigenere_cipher_enc;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] key_char;
  logic       key_valid, key_last, key_clear;
  logic       key_loaded, key_err;
  logic [7:0] ptxt_char;
  logic       ptxt_valid, ptxt_ready;
  logic [7:0] ctxt_char;
  logic       ctxt_valid, ctxt_err, ctxt_ready;

  logic [7:0] k4_char;
  logic       k4_valid, k4_last, k4_clear, k4_loaded, k4_err;
  logic [7:0] p4_char;
  logic       p4_valid, p4_ready;
  logic [7:0] c4_char;
  logic       c4_valid, c4_err, c4_ready;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  vigenere_cipher_enc #(.KEY_MAX_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .key_char(key_char), .key_valid(key_valid), .key_last(key_last),
    .key_clear(key_clear), .key_loaded(key_loaded), .key_err(key_err),
    .ptxt_char(ptxt_char), .ptxt_valid(ptxt_valid), .ptxt_ready(ptxt_ready),
    .ctxt_char(ctxt_char), .ctxt_valid(ctxt_valid), .ctxt_err(ctxt_err),
    .ctxt_ready(ctxt_ready)
  );

  vigenere_cipher_enc #(.KEY_MAX_LEN(4)) dut4 (
    .clk(clk), .rst(rst),
    .key_char(k4_char), .key_valid(k4_valid), .key_last(k4_last),
    .key_clear(k4_clear), .key_loaded(k4_loaded), .key_err(k4_err),
    .ptxt_char(p4_char), .ptxt_valid(p4_valid), .ptxt_ready(p4_ready),
    .ctxt_char(c4_char), .ctxt_valid(c4_valid), .ctxt_err(c4_err),
    .ctxt_ready(c4_ready)
  );

  typedef struct {
    string key;
    string ptxt;
    string ctxt;   // '*' marks an expected error output (8'h00, ctxt_err=1)
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
  endtask

  task automatic load_key(input string k, input bit use_last);
    for (int i = 0; i < k.len(); i++) begin
      key_valid = 1'b1;
      key_char  = k[i];
      key_last  = use_last && (i == k.len() - 1);
      step();
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic send_stream(input string p, input string e);
    ctxt_ready = 1'b1;
    for (int i = 0; i < p.len(); i++) begin
      ptxt_valid = 1'b1;
      ptxt_char  = p[i];
      #1;
      chk($sformatf("ready_%0d", i), ptxt_ready, 1);
      step();
      chk($sformatf("valid_%0d", i), ctxt_valid, 1);
      if (e[i] == 8'h2A) begin
        chk($sformatf("err_%0d", i), ctxt_err, 1);
        chk($sformatf("nul_%0d", i), ctxt_char, 8'h00);
      end else begin
        chk($sformatf("err_%0d", i), ctxt_err, 0);
        chk($sformatf("char_%0d", i), ctxt_char, e[i]);
      end
    end
    ptxt_valid = 1'b0;
    step();
    chk("drained", ctxt_valid, 0);
  endtask

  function automatic logic [8:0] ref_enc(input byte unsigned p, input byte unsigned k);
    if (p >= 65 && p <= 90) return {1'b0, 8'(65 + ((int'(p) - 65) + (int'(k) - 65)) % 26)};
    return 9'h100;
  endfunction

  initial begin
    vecs[0] = '{key: "LEMON", ptxt: "ATTACKATDAWN", ctxt: "LXFOPVEFRNHR"};
    vecs[1] = '{key: "B",     ptxt: "ZZY",          ctxt: "AAZ"};
    vecs[2] = '{key: "AB",    ptxt: "A A",          ctxt: "A*B"};
    vecs[3] = '{key: "KEY",   ptxt: "HELLO, WORLD", ctxt: "RIJVS**UYVJN"};

    rst = 1'b1; key_char = 8'h00; key_valid = 0; key_last = 0; key_clear = 0;
    ptxt_char = 8'h00; ptxt_valid = 0; ctxt_ready = 1;
    k4_char = 8'h00; k4_valid = 0; k4_last = 0; k4_clear = 0;
    p4_char = 8'h00; p4_valid = 0; c4_ready = 1;
    step();
    step();
    chk("rst_key_loaded", key_loaded, 0);
    chk("rst_key_err", key_err, 0);
    chk("rst_ptxt_ready", ptxt_ready, 0);
    chk("rst_ctxt_char", ctxt_char, 8'h00);
    chk("rst_ctxt_valid", ctxt_valid, 0);
    chk("rst_ctxt_err", ctxt_err, 0);
    rst = 1'b0;
    step();

    // Table-driven vectors
    foreach (vecs[v]) begin
      do_clear();
      chk($sformatf("v%0d_idle", v), key_loaded, 0);
      load_key(vecs[v].key, 1'b1);
      chk($sformatf("v%0d_loaded", v), key_loaded, 1);
      send_stream(vecs[v].ptxt, vecs[v].ctxt);
    end

    // Backpressure: key "C", plaintext "ABC"
    do_clear();
    load_key("C", 1'b1);
    ctxt_ready = 1'b1;
    ptxt_valid = 1'b1; ptxt_char = "A";
    step();
    chk("bp_first", ctxt_char, "C");
    ctxt_ready = 1'b0;
    ptxt_char = "B";
    #1;
    chk("bp_ready_low", ptxt_ready, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("bp_hold_char_%0d", i), ctxt_char, "C");
      chk($sformatf("bp_hold_vld_%0d", i), ctxt_valid, 1);
      chk($sformatf("bp_hold_rdy_%0d", i), ptxt_ready, 0);
    end
    ctxt_ready = 1'b1;
    #1;
    chk("bp_release_rdy", ptxt_ready, 1);
    step();
    chk("bp_second", ctxt_char, "D");
    ptxt_char = "C";
    step();
    chk("bp_third", ctxt_char, "E");
    chk("bp_third_vld", ctxt_valid, 1);
    ptxt_valid = 1'b0;
    step();
    chk("bp_drained", ctxt_valid, 0);

    // Bad key character during LOAD
    do_clear();
    key_valid = 1'b1; key_char = "A"; key_last = 1'b0;
    step();
    chk("ke_load", key_loaded, 0);
    key_char = "1";
    step();
    chk("ke_pulse", key_err, 1);
    chk("ke_not_loaded", key_loaded, 0);
    key_valid = 1'b0;
    step();
    chk("ke_pulse_end", key_err, 0);
    load_key("B", 1'b1);
    chk("ke_reload", key_loaded, 1);
    send_stream("A", "B");

    // key_clear with output pending and plaintext presented
    do_clear();
    load_key("B", 1'b1);
    ptxt_valid = 1'b1; ptxt_char = "A"; ctxt_ready = 1'b0;
    step();
    chk("kc_pending", ctxt_valid, 1);
    key_clear = 1'b1;
    step();
    key_clear = 1'b0;
    ptxt_valid = 1'b0;
    #1;
    chk("kc_vld", ctxt_valid, 0);
    chk("kc_rdy", ptxt_ready, 0);
    chk("kc_loaded", key_loaded, 0);
    load_key("B", 1'b1);
    send_stream("A", "B");

    // rst mid-stream
    do_clear();
    load_key("B", 1'b1);
    ptxt_valid = 1'b1; ptxt_char = "Z"; ctxt_ready = 1'b0;
    step();
    chk("rm_pending", ctxt_char, "A");
    rst = 1'b1;
    step();
    rst = 1'b0;
    ptxt_valid = 1'b0;
    #1;
    chk("rm_vld", ctxt_valid, 0);
    chk("rm_char", ctxt_char, 8'h00);
    chk("rm_err", ctxt_err, 0);
    chk("rm_rdy", ptxt_ready, 0);
    chk("rm_loaded", key_loaded, 0);
    chk("rm_key_err", key_err, 0);
    load_key("B", 1'b1);
    send_stream("A", "B");

    // KEY_MAX_LEN=4 overflow: "ABCDE" without key_last
    begin
      string k4 = "ABCDE";
      string e4 = "ABCDA";
      for (int i = 0; i < 5; i++) begin
        k4_valid = 1'b1; k4_char = k4[i];
        step();
        if (i == 2) chk("ov_not_yet", k4_loaded, 0);
        if (i >= 3) chk($sformatf("ov_loaded_%0d", i), k4_loaded, 1);
      end
      k4_valid = 1'b0;
      chk("ov_no_err", k4_err, 0);
      for (int i = 0; i < 5; i++) begin
        p4_valid = 1'b1; p4_char = "A";
        step();
        chk($sformatf("ov_char_%0d", i), c4_char, e4[i]);
      end
      p4_valid = 1'b0;
    end

    // Randomized streams with random backpressure
    for (int t = 0; t < 6; t++) begin
      string key = "";
      string pt = "";
      int klen = $urandom_range(1, 16);
      int plen = 40;
      int sent = 0;
      int mi = 0;
      int cyc = 0;
      logic [8:0] q[$];
      for (int i = 0; i < klen; i++) key = $sformatf("%s%c", key, 8'($urandom_range(65, 90)));
      for (int i = 0; i < plen; i++) begin
        if ($urandom_range(0, 4) == 0) pt = $sformatf("%s%c", pt, 8'($urandom_range(32, 126)));
        else                           pt = $sformatf("%s%c", pt, 8'($urandom_range(65, 90)));
      end
      do_clear();
      load_key(key, 1'b1);
      while ((sent < plen || q.size() > 0) && cyc < 2000) begin
        ptxt_valid = (sent < plen) && ($urandom_range(0, 3) != 0);
        ptxt_char  = (sent < plen) ? pt[sent] : 8'h00;
        ctxt_ready = ($urandom_range(0, 3) != 0);
        #1;
        if (ctxt_valid && ctxt_ready) begin
          if (q.size() == 0) chk($sformatf("rnd%0d_spurious", t), 1, 0);
          else chk($sformatf("rnd%0d_out", t), {ctxt_err, ctxt_char}, q.pop_front());
        end
        if (ptxt_valid && ptxt_ready) begin
          q.push_back(ref_enc(pt[sent], key[mi]));
          if (pt[sent] >= 65 && pt[sent] <= 90) mi = (mi + 1) % klen;
          sent++;
        end
        step();
        cyc++;
      end
      chk($sformatf("rnd%0d_done", t), (sent == plen) && (q.size() == 0), 1);
      ptxt_valid = 1'b0;
      ctxt_ready = 1'b1;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vigenere_cipher_enc.md
# vigenere_cipher_enc

Streaming Vigenère encryptor; the transmit-side counterpart of the plaintext decryption datapath. It holds a loaded key of up to `KEY_MAX_LEN` uppercase characters and encrypts a plaintext byte stream one character per cycle. Key characters are selected cyclically, so the caller supplies only plaintext. Its output stream, together with the same key presented per character, must decrypt back to the original plaintext in the existing decryption block.

## Interface
- `KEY_MAX_LEN`, default 16: maximum key length in characters, ≥ 1. Index width is `$clog2(KEY_MAX_LEN)` (minimum 1).
- `clk` input, 1 bit: the single clock.
- `rst` input, 1 bit: reset, synchronous, active-high.
- `key_char` input, 8 bits: key character (ASCII).
- `key_valid` input, 1 bit: `key_char` is presented this cycle.
- `key_last` input, 1 bit: qualifies `key_valid`; this is the final key character.
- `key_clear` input, 1 bit: discards the key and any pending output; returns to IDLE.
- `key_loaded` output, 1 bit: high while in RUN.
- `key_err` output, 1 bit: one-cycle pulse when a non-uppercase key character is rejected.
- `ptxt_char` input, 8 bits: plaintext character.
- `ptxt_valid` input, 1 bit: `ptxt_char` is presented.
- `ptxt_ready` output, 1 bit: the block accepts plaintext this cycle.
- `ctxt_char` output, 8 bits: ciphertext character.
- `ctxt_valid` output, 1 bit: the output register holds a character.
- `ctxt_err` output, 1 bit: qualifies `ctxt_valid`; the plaintext was not uppercase and `ctxt_char` is 8'h00.
- `ctxt_ready` input, 1 bit: the downstream consumer takes the output.

## Operation
- States are IDLE, LOAD and RUN.
  - Reset enters IDLE.
  - `key_clear` enters IDLE from any state.
- Key load:
  - A key character is accepted when `key_valid` is high in IDLE or LOAD.
  - Each accepted character is written at `key_len` and `key_len` is incremented. The first accepted character moves IDLE to LOAD.
  - An accepted character with `key_last` high moves the FSM to RUN.
  - Accepting the `KEY_MAX_LEN`-th character also moves the FSM to RUN, whatever the value of `key_last`.
  - A key character outside 8'h41..8'h5A pulses `key_err`, sets `key_len` to 0 and returns the FSM to IDLE.
  - `key_valid` is ignored in RUN.
- Encryption:
  - A plaintext character is accepted when `ptxt_valid && ptxt_ready`.
  - `ptxt_ready` = (state == RUN) && (!`ctxt_valid` || `ctxt_ready`).
  - For an uppercase plaintext character `p` and key entry `k` = `key[key_idx]`:
    - s = (p−8'h41) + (k−8'h41), computed 6 bits wide, maximum 50.
    - If s ≥ 26, subtract 26.
    - `ctxt_char` = s + 8'h41.
    - `ctxt_err` = 0.
    - `key_idx` advances, wrapping from `key_len`−1 to 0.
  - For a non-uppercase plaintext character: `ctxt_char` = 8'h00, `ctxt_err` = 1, and `key_idx` does not advance.
  - `key_idx` is set to 0 on entry to RUN.

## Timing
- Reset values: `key_loaded`=0, `key_err`=0, `ptxt_ready`=0, `ctxt_char`=8'h00, `ctxt_valid`=0, `ctxt_err`=0. Internally `key_len`=0 and `key_idx`=0.
- Latency: a plaintext character accepted at edge N appears on `ctxt_*` after edge N. Throughput is 1 character per cycle while `ctxt_ready` is held high.
- Backpressure: while `ctxt_valid && !ctxt_ready`, `ctxt_char` and `ctxt_err` hold stable and `ptxt_ready` is 0.
- Accept and drain can happen in the same cycle; this is allowed and `ctxt_valid` stays 1.
- `key_loaded` rises the cycle after the final key character is accepted. The first plaintext character can be accepted that same cycle.
- `key_clear` has priority over all handshakes in the same cycle:
  - Any plaintext presented that cycle is not accepted.
  - `ctxt_valid` is 0 next cycle.
  - `key_len` is 0.
- `rst` mid-stream has the same effect as `key_clear` and also restores all reset values.
- The key store itself is not reset. Entries are only read below `key_len`.

## Structure
- Package `vigenere_pkg` holds:
  - `UPPERCASE_A_CHAR`, `UPPERCASE_Z_CHAR`, `NUL_CHAR`, `ALPHABET_LEN`=26.
  - State enum `enc_state_t` {IDLE, LOAD, RUN}.
  - Function `is_upper(byte)`.
- Sub-module `vigenere_enc_table` is combinational: it takes `p` and `k` and produces the encrypted letter. It is the mirror of the decryption table.
- The top level contains the FSM, the key register array, `key_idx`/`key_len` counters and the output register.

## Test plan
- Key "LEMON" with `key_last` on 'N'; stream "ATTACKATDAWN" with `ctxt_ready`=1 → "LXFOPVEFRNHR", one character per cycle, first output the cycle after the first accept.
- Wrap-around: key "B", plaintext "ZZY" → "AAZ".
- Non-letters: key "AB", plaintext "A", " ", "A" → 'A'; 8'h00 with `ctxt_err`=1; 'B' (key index not advanced by the space).
- Backpressure: key "C", plaintext "ABC", `ctxt_ready` low for 3 cycles after the first output → 'C' held stable, `ptxt_ready`=0 throughout, then "CDE" in order with no loss or duplication.
- Key errors and overflow:
  - `KEY_MAX_LEN`=4, key "ABCDE" without `key_last` → RUN after 'D'; 'E' is ignored.
  - Key char '1' during LOAD → `key_err` pulse, IDLE, `key_loaded`=0.
- `key_clear` asserted with `ctxt_valid`=1 and plaintext presented → next cycle `ctxt_valid`=0, `ptxt_ready`=0. Reloading key "B" and sending "A" → 'B'. `rst` mid-stream gives the same result with all reset values.
